// File: rtl/gfx_pkg.sv
// Shared graphics types for the polygon draw path.
//   CORDW       - coordinate width in bits
//   vertex_t    - packed {x, y} vertex
//   seq_state_e - draw sequencer FSM state
package gfx_pkg;

  localparam int unsigned CORDW = 16;

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
  } vertex_t;

  typedef enum logic [1:0] {
    StCollect,
    StStart,
    StWait,
    StFinish
  } seq_state_e;

endpackage

// File: rtl/polygon_vertex_buffer.sv
// Vertex register file for the polygon draw sequencer.
// Writes append at the current count; two combinational read ports serve the
// two endpoints of the edge being set up.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   clr_i          - empty the buffer (wins over a same-cycle write)
//   we_i, wdata_i  - append one vertex (ignored when full)
//   rd_a_idx_i/_o  - read port A (edge start vertex)
//   rd_b_idx_i/_o  - read port B (edge end vertex)
//   count_o        - vertices held
//   full_o         - count_o == MaxVerts
module polygon_vertex_buffer
  import gfx_pkg::*;
#(
  parameter int unsigned MaxVerts = 8,
  localparam int unsigned IdxW = $clog2(MaxVerts),
  localparam int unsigned CntW = $clog2(MaxVerts + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            we_i,
  input  vertex_t         wdata_i,
  input  logic [IdxW-1:0] rd_a_idx_i,
  input  logic [IdxW-1:0] rd_b_idx_i,
  output vertex_t         rd_a_o,
  output vertex_t         rd_b_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o
);

  vertex_t         mem_q [MaxVerts];
  logic [CntW-1:0] count_q;
  logic [IdxW-1:0] wr_idx;
  logic            wr_en;

  assign full_o  = (count_q == CntW'(MaxVerts));
  assign wr_en   = we_i && !clr_i && !full_o;
  assign wr_idx  = count_q[IdxW-1:0];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

  // Write-through reads: the frame can close in the same cycle as the final
  // y word, and the edge endpoint registers must already see that vertex.
  always_comb begin
    rd_a_o = mem_q[rd_a_idx_i];
    rd_b_o = mem_q[rd_b_idx_i];
    if (wr_en && (rd_a_idx_i == wr_idx)) rd_a_o = wdata_i;
    if (wr_en && (rd_b_idx_i == wr_idx)) rd_b_o = wdata_i;
  end

endmodule

// File: rtl/polygon_draw_sequencer.sv
// Polygon draw sequencer: buffers a vertex list streamed as alternating x/y
// words, then drives the line rasterizer once per edge with a start/ready
// request and a done strobe per line.
// Build option: define POLY_CLOSE_EDGE_EN to also draw vertex n-1 -> vertex 0.
// Ports:
//   clock, reset       - clock, synchronous active-high reset
//   word_valid/data    - received word strobe and payload (x, y, x, y...)
//   frame_end          - frame close strobe
//   line_start/ready   - edge request handshake to the rasterizer
//   line_x0..line_y1   - registered edge endpoints
//   line_done          - rasterizer finished the current edge
//   busy               - draw sequence in progress
//   frame_done         - one-cycle strobe after the last edge
//   overflow           - sticky, words dropped while the buffer was full
//   vert_count         - vertices held
module polygon_draw_sequencer
  import gfx_pkg::*;
#(
  parameter int unsigned CORDW     = gfx_pkg::CORDW,
  parameter int unsigned MAX_VERTS = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           word_valid,
  input  logic [CORDW-1:0]               word_data,
  input  logic                           frame_end,
  output logic                           line_start,
  input  logic                           line_ready,
  output logic [CORDW-1:0]               line_x0,
  output logic [CORDW-1:0]               line_y0,
  output logic [CORDW-1:0]               line_x1,
  output logic [CORDW-1:0]               line_y1,
  input  logic                           line_done,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overflow,
  output logic [$clog2(MAX_VERTS+1)-1:0] vert_count
);

  localparam int unsigned IdxW = $clog2(MAX_VERTS);
  localparam int unsigned CntW = $clog2(MAX_VERTS + 1);

  seq_state_e      state_q, state_d;
  logic [CORDW-1:0] pend_x_q, pend_x_d;
  logic            have_x_q, have_x_d;
  logic [IdxW-1:0] edge_q, edge_d;
  logic            ovf_q, ovf_d;
  vertex_t         ep_a_q, ep_a_d;
  vertex_t         ep_b_q, ep_b_d;

  logic            buf_we;
  logic            buf_clr;
  vertex_t         buf_wdata;
  logic [IdxW-1:0] rd_a_idx;
  logic [IdxW-1:0] rd_b_idx;
  vertex_t         rd_a;
  vertex_t         rd_b;
  logic [CntW-1:0] count;
  logic            full;

  logic [CntW-1:0] n_eff;
  logic [CntW-1:0] last_edge;
  logic [CntW-1:0] nxt;
  logic            drawing_d;

  polygon_vertex_buffer #(
    .MaxVerts (MAX_VERTS)
  ) u_buf (
    .clk_i      (clock),
    .rst_i      (reset),
    .clr_i      (buf_clr),
    .we_i       (buf_we),
    .wdata_i    (buf_wdata),
    .rd_a_idx_i (rd_a_idx),
    .rd_b_idx_i (rd_b_idx),
    .rd_a_o     (rd_a),
    .rd_b_o     (rd_b),
    .count_o    (count),
    .full_o     (full)
  );

  // Index of the final edge; only consulted while drawing, when count >= 2.
`ifdef POLY_CLOSE_EDGE_EN
  assign last_edge = count - CntW'(1);
`else
  assign last_edge = count - CntW'(2);
`endif

  always_comb begin
    state_d   = state_q;
    pend_x_d  = pend_x_q;
    have_x_d  = have_x_q;
    edge_d    = edge_q;
    ovf_d     = ovf_q;
    buf_we    = 1'b0;
    buf_clr   = 1'b0;
    buf_wdata = '{x: pend_x_q, y: word_data};
    n_eff     = count;

    unique case (state_q)
      StCollect: begin
        if (word_valid) begin
          if (full) begin
            ovf_d = 1'b1;
          end else if (!have_x_q) begin
            pend_x_d = word_data;
            have_x_d = 1'b1;
          end else begin
            buf_we   = 1'b1;
            have_x_d = 1'b0;
          end
        end
        // Vertex count including a write landing this cycle.
        n_eff = count + CntW'(buf_we);
        if (frame_end) begin
          have_x_d = 1'b0;
          edge_d   = '0;
          if (n_eff >= CntW'(2)) begin
            state_d = StStart;
          end else begin
            buf_clr = 1'b1;
          end
        end
      end
      StStart: begin
        if (line_ready) state_d = StWait;
      end
      StWait: begin
        if (line_done) begin
          if (CntW'(edge_q) == last_edge) begin
            state_d = StFinish;
          end else begin
            edge_d  = edge_q + IdxW'(1);
            state_d = StStart;
          end
        end
      end
      StFinish: begin
        buf_clr  = 1'b1;
        ovf_d    = 1'b0;
        have_x_d = 1'b0;
        state_d  = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  // Endpoint registers follow the next edge index so they are valid in the
  // first START cycle and hold through WAIT; zero outside a draw.
  always_comb begin
    drawing_d = (state_d == StStart) || (state_d == StWait);
    nxt       = CntW'(edge_d) + CntW'(1);
    rd_a_idx  = edge_d;
    rd_b_idx  = (nxt == n_eff) ? '0 : nxt[IdxW-1:0];
    ep_a_d    = drawing_d ? rd_a : '0;
    ep_b_d    = drawing_d ? rd_b : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StCollect;
      pend_x_q <= '0;
      have_x_q <= 1'b0;
      edge_q   <= '0;
      ovf_q    <= 1'b0;
      ep_a_q   <= '0;
      ep_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_x_q <= pend_x_d;
      have_x_q <= have_x_d;
      edge_q   <= edge_d;
      ovf_q    <= ovf_d;
      ep_a_q   <= ep_a_d;
      ep_b_q   <= ep_b_d;
    end
  end

  assign line_start = (state_q == StStart);
  assign busy       = (state_q != StCollect);
  assign frame_done = (state_q == StFinish);
  assign overflow   = ovf_q;
  assign vert_count = count;
  assign line_x0    = ep_a_q.x;
  assign line_y0    = ep_a_q.y;
  assign line_x1    = ep_b_q.x;
  assign line_y1    = ep_b_q.y;

endmodule
